// File: rtl/cmos_spi_config.sv
// CMOS sensor register-file programmer: writes each table entry over SPI (mode 0),
// reads it back, and requests a sensor reset and retry on a readback mismatch.
// The chip select stays low for 34*CLK_DIV cycles per frame: a CLK_DIV lead-in,
// then 16 bits of CLK_DIV high plus CLK_DIV low, then a CLK_DIV tail.
module cmos_spi_config #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned WAIT_CYCLES = 1024,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic              clk_input,
  input  logic              reset_n,
  input  logic              start_config,
  input  logic              sensor_released,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [14:0]       rom_data,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              request_reset,
  output logic              config_done,
  output logic              config_fail,
  output logic [1:0]        retry_count
);

  localparam int unsigned DIV_W    = $clog2(CLK_DIV) + 1;
  localparam int unsigned CNT_MAX0 = (WAIT_CYCLES > 16) ? WAIT_CYCLES : 16;
  localparam int unsigned CNT_MAX  = (CNT_MAX0 > 2 * CLK_DIV) ? CNT_MAX0 : 2 * CLK_DIV;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_SETTLE, S_FETCH, S_WRITE, S_GAP, S_READ,
    S_CHECK, S_RETRY, S_WAIT_START, S_DONE, S_FAIL
  } state_t;

  typedef enum logic [1:0] {PH_LEAD, PH_HIGH, PH_LOW, PH_TAIL} phase_t;

  state_t             r_state;
  phase_t             r_phase;
  logic [DIV_W-1:0]   r_div;
  logic [3:0]         r_bit;
  logic [CNT_W-1:0]   r_cnt;
  logic [15:0]        r_shift;
  logic [15:0]        r_rx;
  logic [6:0]         r_reg_addr;
  logic [7:0]         r_reg_data;
  logic               r_gap_to_read;
  logic               r_fetch_wait;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic               r_cs_n;
  logic               r_sclk;
  logic               r_mosi;
  logic               r_req;
  logic               r_done;
  logic               r_fail;
  logic [1:0]         r_retry;

  logic w_start;
  logic w_abort;
  logic w_div_end;

  // Qualified start, abort condition for the active states, and SCLK phase boundary
  always_comb begin
    w_start   = start_config && sensor_released;
    w_abort   = !sensor_released &&
                (r_state inside {S_SETTLE, S_FETCH, S_WRITE, S_GAP, S_READ, S_CHECK});
    w_div_end = (r_div == DIV_W'(CLK_DIV - 1));
  end

  // Sequencer FSM with embedded SPI shift engine; all outputs registered
  always_ff @(posedge clk_input or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_phase       <= PH_LEAD;
      r_div         <= '0;
      r_bit         <= '0;
      r_cnt         <= '0;
      r_shift       <= '0;
      r_rx          <= '0;
      r_reg_addr    <= '0;
      r_reg_data    <= '0;
      r_gap_to_read <= 1'b0;
      r_fetch_wait  <= 1'b0;
      r_rom_addr    <= '0;
      r_cs_n        <= 1'b1;
      r_sclk        <= 1'b0;
      r_mosi        <= 1'b0;
      r_req         <= 1'b0;
      r_done        <= 1'b0;
      r_fail        <= 1'b0;
      r_retry       <= '0;
    end else if (w_abort) begin
      r_state <= S_IDLE;
      r_phase <= PH_LEAD;
      r_div   <= '0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state    <= S_SETTLE;
            r_rom_addr <= '0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
            r_cnt      <= '0;
          end
        end
        S_SETTLE: begin
          if (r_cnt == CNT_W'(WAIT_CYCLES - 1)) begin
            r_state      <= S_FETCH;
            r_fetch_wait <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_FETCH: begin
          if (!r_fetch_wait) begin
            r_fetch_wait <= 1'b1;
          end else begin
            r_reg_addr <= rom_data[14:8];
            r_reg_data <= rom_data[7:0];
            r_shift    <= {1'b1, rom_data};
            r_mosi     <= 1'b1;
            r_cs_n     <= 1'b0;
            r_phase    <= PH_LEAD;
            r_div      <= '0;
            r_bit      <= '0;
            r_state    <= S_WRITE;
          end
        end
        S_WRITE, S_READ: begin
          if (w_div_end) begin
            r_div <= '0;
            case (r_phase)
              PH_LEAD: begin
                r_phase <= PH_HIGH;
                r_sclk  <= 1'b1;
                r_rx    <= {r_rx[14:0], spi_miso};
              end
              PH_HIGH: begin
                r_phase <= PH_LOW;
                r_sclk  <= 1'b0;
                r_shift <= {r_shift[14:0], 1'b0};
                r_mosi  <= r_shift[14];
              end
              PH_LOW: begin
                if (r_bit == 4'd15) begin
                  r_phase <= PH_TAIL;
                end else begin
                  r_bit   <= r_bit + 4'd1;
                  r_phase <= PH_HIGH;
                  r_sclk  <= 1'b1;
                  r_rx    <= {r_rx[14:0], spi_miso};
                end
              end
              PH_TAIL: begin
                r_phase <= PH_LEAD;
                r_cs_n  <= 1'b1;
                r_mosi  <= 1'b0;
                r_cnt   <= '0;
                if (r_state == S_WRITE) begin
                  r_gap_to_read <= 1'b1;
                  r_state       <= S_GAP;
                end else begin
                  r_state <= S_CHECK;
                end
              end
            endcase
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == CNT_W'(2 * CLK_DIV - 1)) begin
            if (r_gap_to_read) begin
              r_shift <= {1'b0, r_reg_addr, 8'h00};
              r_mosi  <= 1'b0;
              r_cs_n  <= 1'b0;
              r_phase <= PH_LEAD;
              r_div   <= '0;
              r_bit   <= '0;
              r_state <= S_READ;
            end else begin
              r_fetch_wait <= 1'b0;
              r_state      <= S_FETCH;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_CHECK: begin
          if (r_rx[7:0] == r_reg_data) begin
            if (r_rom_addr == ADDR_W'(NUM_REGS - 1)) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_rom_addr    <= r_rom_addr + ADDR_W'(1);
              r_gap_to_read <= 1'b0;
              r_cnt         <= '0;
              r_state       <= S_GAP;
            end
          end else if (r_retry < 2'(MAX_RETRY)) begin
            r_retry <= r_retry + 2'd1;
            r_req   <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_RETRY;
          end else begin
            r_fail  <= 1'b1;
            r_state <= S_FAIL;
          end
        end
        S_RETRY: begin
          if (r_cnt == CNT_W'(15)) begin
            r_req   <= 1'b0;
            r_state <= S_WAIT_START;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WAIT_START: begin
          if (w_start) begin
            r_rom_addr <= '0;
            r_cnt      <= '0;
            r_state    <= S_SETTLE;
          end
        end
        S_DONE, S_FAIL: begin
          if (w_start) begin
            r_rom_addr <= '0;
            r_retry    <= '0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
            r_cnt      <= '0;
            r_state    <= S_SETTLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rom_addr      = r_rom_addr;
  assign spi_cs_n      = r_cs_n;
  assign spi_sclk      = r_sclk;
  assign spi_mosi      = r_mosi;
  assign request_reset = r_req;
  assign config_done   = r_done;
  assign config_fail   = r_fail;
  assign retry_count   = r_retry;

endmodule
